// File: rtl/ps2_frame_ctrl.sv
// PS/2 11-bit frame receiver. It checks parity, the stop bit and the inter-bit timeout, and feeds a one-entry valid/ack buffer.
// Results appear the cycle after the stop-bit edge. A good frame that arrives while the buffer is full is dropped and sets the sticky overrun flag.
module ps2_frame_ctrl #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data,
    input  logic       en,
    input  logic       ack,
    output logic [7:0] code,
    output logic       valid,
    output logic       err,
    output logic       overrun,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [7:0]    sr;
    logic          p;
    logic [2:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          good;

    assign good = data & (^{sr, p});
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= 8'h00;
            p       <= 1'b0;
            bcnt    <= 3'd0;
            tcnt    <= '0;
            code    <= 8'h00;
            valid   <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            err <= 1'b0;

            if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            // Gap timer only runs on strobe-free cycles, so a strobe on the expiry edge wins.
            if (state != IDLE && !en) begin
                if (tcnt != TMAX) begin
                    tcnt <= tcnt + 1'b1;
                end
                if (tcnt == TMAX - 1'b1) begin
                    state <= IDLE;
                    err   <= 1'b1;
                end
            end

            if (en) begin
                case (state)
                    IDLE: begin
                        if (!data) begin
                            state <= DATA;
                            bcnt  <= 3'd0;
                            tcnt  <= '0;
                        end
                    end
                    DATA: begin
                        sr   <= {data, sr[7:1]};
                        bcnt <= bcnt + 1'b1;
                        tcnt <= '0;
                        if (bcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        p     <= data;
                        tcnt  <= '0;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        tcnt  <= '0;
                        if (good) begin
                            if (!valid || ack) begin
                                code    <= sr;
                                valid   <= 1'b1;
                                overrun <= 1'b0;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// Bench for ps2_frame_ctrl with TIMEOUT=16, using directed frames followed by random frames.
// A frame-level model of the scan-code buffer supplies the expected values.
module tb_ps2_frame_ctrl;
    logic       clk;
    logic       reset;
    logic       data;
    logic       en;
    logic       ack;
    logic [7:0] code;
    logic       valid;
    logic       err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_code;
    logic       m_valid;
    logic       m_ov;

    ps2_frame_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .data(data), .en(en), .ack(ack),
        .code(code), .valid(valid), .err(err), .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_err);
        check8({tag, "_code"}, code, m_code);
        check1({tag, "_valid"}, valid, m_valid);
        check1({tag, "_ovr"}, overrun, m_ov);
        check1({tag, "_err"}, err, exp_err);
        check1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic strobe(input logic b);
        en   = 1'b1;
        data = b;
        @(negedge clk);
        en   = 1'b0;
        data = 1'($urandom_range(0, 1));
    endtask

    // One full frame; long_at selects a strobe followed by the longest legal gap (15 idle cycles).
    task automatic frame(input string tag, input logic [7:0] b, input logic pb, input logic sb,
                         input logic ak, input int gap_max, input int long_at);
        logic [10:0] f;
        logic        good;
        int          g;
        f = {sb, pb, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ack = (i == 10) && ak;
            strobe(f[i]);
            ack = 1'b0;
            if (i == 0) check1({tag, "_busy_start"}, busy, 1'b1);
            if (i < 10) begin
                g = (i == long_at) ? 15 : int'($urandom_range(1, gap_max));
                repeat (g) @(negedge clk);
            end
        end
        good = sb && ((^b) != pb);
        if (m_valid && ak) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
        if (good) begin
            if (!m_valid) begin
                m_code  = b;
                m_valid = 1'b1;
                m_ov    = 1'b0;
            end else begin
                m_ov = 1'b1;
            end
        end
        check_outs(tag, !good);
        @(negedge clk);
        check1({tag, "_err_gone"}, err, 1'b0);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
        check1({tag, "_valid"}, valid, m_valid);
        check1({tag, "_ovr"}, overrun, m_ov);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp;
        logic       rs;
        reset = 1'b1;
        data  = 1'b1;
        en    = 1'b0;
        ack   = 1'b0;
        m_code = 8'h00; m_valid = 1'b0; m_ov = 1'b0;
        #12;
        check_outs("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        frame("good1c", 8'h1C, 1'b0, 1'b1, 1'b0, 3, -1);
        do_ack("ack1");
        frame("badpar", 8'h1C, 1'b1, 1'b1, 1'b0, 3, -1);
        frame("badstop", 8'h1C, 1'b0, 1'b0, 1'b0, 3, -1);

        frame("ovr_a", 8'h1C, 1'b0, 1'b1, 1'b0, 2, -1);
        frame("ovr_b", 8'hF0, 1'b1, 1'b1, 1'b0, 2, -1);
        do_ack("ack_ovr");

        frame("sim_a", 8'h1C, 1'b0, 1'b1, 1'b0, 2, -1);
        frame("sim_b", 8'hF0, 1'b1, 1'b1, 1'b1, 2, -1);
        do_ack("ack_sim");

        frame("maxgap", 8'hA5, 1'b1, 1'b1, 1'b0, 4, 4);
        do_ack("ack_maxgap");

        // Timeout: start bit plus three data bits, then silence.
        strobe(1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) repeat (2) @(negedge clk);
            strobe(1'(i & 1));
        end
        repeat (15) @(negedge clk);
        check1("to_err_early", err, 1'b0);
        check1("to_busy_early", busy, 1'b1);
        @(negedge clk);
        check1("to_err", err, 1'b1);
        check1("to_busy", busy, 1'b0);
        @(negedge clk);
        check1("to_err_gone", err, 1'b0);
        frame("after_to", 8'h1C, 1'b0, 1'b1, 1'b0, 3, -1);

        // Idle glitch: a high bit with no start bit must not open a frame.
        strobe(1'b1);
        check1("glitch_busy", busy, 1'b0);
        @(negedge clk);
        check1("glitch_busy2", busy, 1'b0);
        check1("glitch_err", err, 1'b0);

        // Reset five bits into a frame, with a byte still pending from the frame before.
        for (int i = 0; i < 5; i++) begin
            strobe(1'(i == 2));
            @(negedge clk);
        end
        #3 reset = 1'b1;
        #1;
        m_code = 8'h00; m_valid = 1'b0; m_ov = 1'b0;
        check_outs("midrst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check1("midrst_err", err, 1'b0);
        frame("after_rst", 8'h3B, 1'b0, 1'b1, 1'b0, 3, -1);

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rp = (~^rb) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 7) != 0);
            frame("rnd", rb, rp, rs, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)), -1);
            if ($urandom_range(0, 2) == 0) do_ack("rnd_ack");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_frame_ctrl.md
# ps2_frame_ctrl

Sequencing controller for the keyboard serial input path of the calculator. It tracks a PS/2-style 11-bit frame: start 0, 8 data bits LSB-first, odd parity, stop 1. Bits arrive one per `en` strobe. It validates parity and stop, enforces an inter-bit timeout, and presents each good scan code to the key decoder through a one-entry valid/ack buffer.

## Interface
- `TIMEOUT`, default 4096: maximum `clk` cycles allowed between consecutive `en` strobes inside a frame.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  1  serial line level, already synchronised; sampled only when `en`=1.
- `en`  in  1  one-cycle bit strobe (falling edge of keyboard clock, synchronised).
- `ack`  in  1  consumer accepts `code`; meaningful only while `valid`=1.
- `code`  out  8  last accepted scan code.
- `valid`  out  1  `code` holds an unconsumed byte.
- `err`  out  1  one-cycle pulse on framing, parity or timeout error.
- `overrun`  out  1  sticky; a good frame was dropped because the buffer was full.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - `en`=1 with `data`=0 → DATA, bit counter = 0, timeout counter = 0.
  - `en`=1 with `data`=1 is ignored (line idle or glitch).
- DATA: each `en` shifts `sr <= {data, sr[7:1]}` and increments the 3-bit counter. The strobe that carries the 8th bit (counter = 7) → PARITY.
- PARITY: next `en` latches `p <= data` → STOP.
- STOP: next `en` → IDLE, and the frame is evaluated:
  - good when `data`=1 and `^{sr,p}`=1 (odd parity);
  - good and buffer free (`valid`=0, or `ack`=1 this cycle) → `code <= sr`, `valid <= 1`;
  - good and buffer full, no `ack` → `code` unchanged, `overrun <= 1`, byte dropped;
  - bad stop or parity → `err` pulses 1 for one cycle, buffer untouched.
- Timeout:
  - In any non-IDLE state, the counter increments every cycle without `en` and clears on `en`.
  - When the counter reaches `TIMEOUT`, state → IDLE and `err` pulses. The partial frame is discarded.
  - Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Handshake:
  - `ack` while `valid`=1 → `valid <= 0` and `overrun <= 0` next edge.
  - `ack` while `valid`=0 is ignored.
- Simultaneous `ack` and good-frame delivery: new byte loads, `valid` stays 1, `overrun` cleared.
- Simultaneous timeout expiry and `en`: `en` wins; the bit is processed and the counter clears.
- `busy` is a decode of the state register. `err` is registered.

## Timing
- Reset (async, immediate) values:
  - state = IDLE;
  - `code` = 8'h00, `valid` = 0, `err` = 0, `overrun` = 0, `busy` = 0;
  - `sr`, `p` and both counters = 0.
- Reset asserted mid-frame aborts the frame with no `err` pulse. After release the block waits for a fresh start bit.
- Latency:
  - `valid`/`code`/`err`/`overrun` update on the same edge that samples the stop-bit `en`;
  - they are visible in the following cycle.
- `busy` rises the cycle after the start-bit edge and falls the cycle after the stop-bit edge or the timeout edge.
- Frame length is exactly 11 `en` strobes. Back-to-back frames need no idle gap: the strobe after STOP may be the next start bit.
- `valid` holds until `ack`. `code` is stable while `valid`=1.

## Test plan
- **Good frame:** frame 0x1C, bits 0,0,0,1,1,1,0,0,0,0,1 on successive `en` → `code`=0x1C, `valid`=1, `err`=0, `busy`=0 after the stop bit.
- **Bad parity:** 0x1C frame with parity bit 1 → `err` one-cycle pulse, `valid` stays 0. Same result with stop bit 0.
- **Overrun and ack:** frame 0x1C, then frame 0xF0 (parity 1) with no `ack` → `code`=0x1C, `overrun`=1. Then `ack` → `valid`=0, `overrun`=0.
- **Simultaneous ack:** `ack` asserted on the stop-bit edge of 0xF0 while 0x1C is pending → `code`=0xF0, `valid`=1, `overrun`=0.
- **Timeout:** `TIMEOUT`=16; start bit plus 3 data bits, then no `en` → `err` pulses on cycle 16 after the last strobe, `busy`=0. A following full 0x1C frame is received correctly.
- **Reset and idle glitch:**
  - Assert `reset` after 5 bits → outputs at reset values immediately, no `err`; a subsequent frame decodes correctly.
  - An `en` with `data`=1 in IDLE leaves `busy`=0.
